// File: rtl/dpi_pkg.sv
// Shared types and sizes for the DPI packet sequencer and its stream table.
package dpi_pkg;
    localparam int SID_W     = 6;
    localparam int N_STREAMS = 64;
    localparam int CHAR_W    = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SETTLE,
        S_STREAM,
        S_DRAIN,
        S_EOP,
        S_RESULT
    } state_t;
endpackage

// File: rtl/dpi_stream_table.sv
// Per-stream regex enable masks (block RAM) plus the seen-bitmap, with a
// registered single-cycle read of both for one stream ID.
module dpi_stream_table
    import dpi_pkg::*;
#(
    parameter int N_REGEX = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_en,
    input  logic [SID_W-1:0]   wr_sid,
    input  logic [N_REGEX-1:0] wr_mask,
    input  logic               clr,
    input  logic               set_en,
    input  logic [SID_W-1:0]   set_sid,
    input  logic               rd_en,
    input  logic [SID_W-1:0]   rd_sid,
    output logic [N_REGEX-1:0] rd_mask,
    output logic               rd_seen
);
    logic [N_REGEX-1:0]   mask_mem [N_STREAMS];
    logic [N_REGEX-1:0]   mask_q_reg;
    logic [N_STREAMS-1:0] mask_vld_reg, mask_vld_next;
    logic [N_STREAMS-1:0] seen_reg, seen_next;
    logic                 rd_vld_reg;
    logic                 rd_seen_reg;

    // The RAM itself cannot be cleared by reset, so a per-entry written flag
    // gates its read data; an unwritten entry reads as an all-zero mask.
    always_ff @(posedge clk) begin
        if (wr_en)
            mask_mem[wr_sid] <= wr_mask;
        if (rd_en)
            mask_q_reg <= mask_mem[rd_sid];
    end

    // A set from LOAD survives a simultaneous clear of the whole bitmap.
    generate
        for (genvar gi = 0; gi < N_STREAMS; gi++) begin : g_bits
            assign mask_vld_next[gi] = mask_vld_reg[gi] | (wr_en && (wr_sid == SID_W'(gi)));
            assign seen_next[gi]     = (set_en && (set_sid == SID_W'(gi))) | (seen_reg[gi] & ~clr);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            mask_vld_reg <= '0;
            seen_reg     <= '0;
            rd_vld_reg   <= 1'b0;
            rd_seen_reg  <= 1'b0;
        end else begin
            mask_vld_reg <= mask_vld_next;
            seen_reg     <= seen_next;
            if (rd_en) begin
                rd_vld_reg  <= mask_vld_reg[rd_sid];
                rd_seen_reg <= seen_reg[rd_sid];
            end
        end
    end

    assign rd_mask = rd_vld_reg ? mask_q_reg : '0;
    assign rd_seen = rd_seen_reg;
endmodule

// File: rtl/dpi_pkt_sequencer.sv
// Per-packet controller for the DPI regex bank: loads matcher state, streams
// bytes, waits out matcher latency, pulses eop and returns the masked result.
module dpi_pkt_sequencer
    import dpi_pkg::*;
#(
    parameter int N_REGEX   = 8,
    parameter int MATCH_LAT = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [CHAR_W-1:0]  in_data,
    input  logic               in_sop,
    input  logic               in_eop,
    input  logic [SID_W-1:0]   in_sid,
    input  logic               cfg_we,
    input  logic [SID_W-1:0]   cfg_sid,
    input  logic [N_REGEX-1:0] cfg_mask,
    input  logic               cfg_clr,
    output logic [CHAR_W-1:0]  char_in,
    output logic               char_in_vld,
    output logic               load_state,
    output logic               new_stream_id,
    output logic               eop,
    output logic [SID_W-1:0]   stream_id,
    output logic [N_REGEX-1:0] enable,
    input  logic [N_REGEX-1:0] fired,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [SID_W-1:0]   res_sid,
    output logic [N_REGEX-1:0] res_fired,
    output logic [15:0]        pkt_count,
    output logic               err
);
    state_t             state_reg, state_next;
    logic [SID_W-1:0]   sid_reg;
    logic [N_REGEX-1:0] mask_reg;
    logic [2:0]         drain_cnt_reg;
    logic [CHAR_W-1:0]  char_reg;
    logic               char_vld_reg;
    logic [SID_W-1:0]   res_sid_reg;
    logic [N_REGEX-1:0] res_fired_reg;
    logic [15:0]        pkt_count_reg;
    logic               err_reg;
    logic               sop_start, accept, drop;
    logic [N_REGEX-1:0] tbl_mask;
    logic               tbl_seen;

    assign sop_start = (state_reg == S_IDLE) && in_valid && in_sop;

    dpi_stream_table #(.N_REGEX(N_REGEX)) u_table (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (cfg_we),
        .wr_sid  (cfg_sid),
        .wr_mask (cfg_mask),
        .clr     (cfg_clr),
        .set_en  (state_reg == S_LOAD),
        .set_sid (sid_reg),
        .rd_en   (sop_start),
        .rd_sid  (in_sid),
        .rd_mask (tbl_mask),
        .rd_seen (tbl_seen)
    );

    always_comb begin
        state_next    = state_reg;
        in_ready      = 1'b0;
        load_state    = 1'b0;
        new_stream_id = 1'b0;
        eop           = 1'b0;
        enable        = '0;
        res_valid     = 1'b0;
        accept        = 1'b0;
        drop          = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (in_valid) begin
                    if (in_sop) begin
                        state_next = S_LOAD;
                    end else begin
                        in_ready = 1'b1;
                        drop     = 1'b1;
                    end
                end
            end
            S_LOAD: begin
                load_state    = 1'b1;
                new_stream_id = ~tbl_seen;
                state_next    = S_SETTLE;
            end
            S_SETTLE: state_next = S_STREAM;
            S_STREAM: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept = 1'b1;
                    if (in_eop)
                        state_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (drain_cnt_reg == 3'(MATCH_LAT))
                    state_next = S_EOP;
            end
            S_EOP: begin
                eop        = 1'b1;
                enable     = mask_reg;
                state_next = S_RESULT;
            end
            S_RESULT: begin
                res_valid = 1'b1;
                if (res_ready)
                    state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= S_IDLE;
            sid_reg       <= '0;
            mask_reg      <= '0;
            drain_cnt_reg <= '0;
            char_reg      <= '0;
            char_vld_reg  <= 1'b0;
            res_sid_reg   <= '0;
            res_fired_reg <= '0;
            pkt_count_reg <= '0;
            err_reg       <= 1'b0;
        end else begin
            state_reg    <= state_next;
            char_vld_reg <= accept;
            if (accept)
                char_reg <= in_data;
            if (sop_start)
                sid_reg <= in_sid;
            // Mask is frozen at LOAD so config writes never touch the live packet.
            if (state_reg == S_LOAD)
                mask_reg <= tbl_mask;
            drain_cnt_reg <= (state_reg == S_DRAIN) ? drain_cnt_reg + 3'd1 : 3'd0;
            if (drop)
                err_reg <= 1'b1;
            if (state_reg == S_EOP) begin
                res_fired_reg <= fired & mask_reg;
                res_sid_reg   <= sid_reg;
                pkt_count_reg <= pkt_count_reg + 16'd1;
            end
        end
    end

    assign char_in     = char_reg;
    assign char_in_vld = char_vld_reg;
    assign stream_id   = sid_reg;
    assign res_sid     = res_sid_reg;
    assign res_fired   = res_fired_reg;
    assign pkt_count   = pkt_count_reg;
    assign err         = err_reg;
endmodule

// File: tb/tb_dpi_pkt_sequencer.sv
// Randomized bench for dpi_pkt_sequencer: packet-level model of seen/mask
// tables and the documented cycle timeline of each packet.
module tb_dpi_pkt_sequencer;
    localparam int N_REGEX   = 8;
    localparam int MATCH_LAT = 2;

    logic               clk = 1'b0;
    logic               rst;
    logic               in_valid, in_ready, in_sop, in_eop;
    logic [7:0]         in_data;
    logic [5:0]         in_sid;
    logic               cfg_we, cfg_clr;
    logic [5:0]         cfg_sid;
    logic [N_REGEX-1:0] cfg_mask;
    logic [7:0]         char_in;
    logic               char_in_vld, load_state, new_stream_id, eop;
    logic [5:0]         stream_id;
    logic [N_REGEX-1:0] enable, fired;
    logic               res_valid, res_ready;
    logic [5:0]         res_sid;
    logic [N_REGEX-1:0] res_fired;
    logic [15:0]        pkt_count;
    logic               err;

    always #5 clk = ~clk;

    dpi_pkt_sequencer #(.N_REGEX(N_REGEX), .MATCH_LAT(MATCH_LAT)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_sop(in_sop), .in_eop(in_eop), .in_sid(in_sid),
        .cfg_we(cfg_we), .cfg_sid(cfg_sid), .cfg_mask(cfg_mask), .cfg_clr(cfg_clr),
        .char_in(char_in), .char_in_vld(char_in_vld),
        .load_state(load_state), .new_stream_id(new_stream_id), .eop(eop),
        .stream_id(stream_id), .enable(enable), .fired(fired),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_sid(res_sid), .res_fired(res_fired),
        .pkt_count(pkt_count), .err(err)
    );

    int                 n_cmp = 0;
    int                 n_bad = 0;
    logic [N_REGEX-1:0] mask_m [64];
    bit                 seen_m [64];
    int                 pkt_m;
    bit                 err_m;
    bit                 fired_all;
    logic [7:0]         pkt_bytes [$];

    task automatic model_reset();
        for (int i = 0; i < 64; i++) begin
            mask_m[i] = '0;
            seen_m[i] = 1'b0;
        end
        pkt_m = 0;
        err_m = 1'b0;
    endtask

    task automatic fill_bytes(input int n);
        pkt_bytes.delete();
        for (int i = 0; i < n; i++)
            pkt_bytes.push_back(8'($urandom));
    endtask

    task automatic cfg_write(input int sid, input logic [N_REGEX-1:0] m);
        @(posedge clk); #1;
        cfg_we = 1'b1; cfg_sid = 6'(sid); cfg_mask = m;
        @(posedge clk); #1;
        cfg_we = 1'b0;
        mask_m[sid] = m;
    endtask

    task automatic cfg_clear();
        @(posedge clk); #1;
        cfg_clr = 1'b1;
        @(posedge clk); #1;
        cfg_clr = 1'b0;
        for (int i = 0; i < 64; i++) seen_m[i] = 1'b0;
    endtask

    // One packet, cycle 0 = SOP visible in IDLE. Every cycle is checked
    // against the timeline derived from the packet-level plan.
    task automatic run_packet(input int sid, input int hold, input bit gaps,
                              input bit clr_load, input bit wr_mid);
        int                 n, c, tn, eop_c, res_c, end_c, kidx;
        int                 acc_cyc [$];
        logic [7:0]         vld_byte;
        bit                 acc_prev, acc_now, exp_new;
        logic [N_REGEX-1:0] exp_mask, fired_eop, new_mask;
        n        = pkt_bytes.size();
        exp_new  = !seen_m[sid];
        exp_mask = mask_m[sid];
        new_mask = N_REGEX'($urandom);
        c = 3;
        for (int k = 0; k < n; k++) begin
            if (gaps && k > 0) c += $urandom_range(0, 2);
            acc_cyc.push_back(c);
            c++;
        end
        tn        = acc_cyc[n-1];
        eop_c     = tn + MATCH_LAT + 2;
        res_c     = eop_c + 1;
        end_c     = res_c + hold + 1;
        kidx      = 0;
        acc_prev  = 1'b0;
        vld_byte  = '0;
        fired_eop = '0;
        for (int cy = 0; cy <= end_c; cy++) begin
            @(posedge clk); #1;
            acc_now = 1'b0;
            cfg_we  = 1'b0;
            cfg_clr = (clr_load && cy == 1);
            cfg_sid = 6'($urandom);
            cfg_mask = N_REGEX'($urandom);
            if (wr_mid && cy == 4) begin
                cfg_we = 1'b1; cfg_sid = 6'(sid); cfg_mask = new_mask;
            end
            fired = fired_all ? '1 : N_REGEX'($urandom);
            if (cy == eop_c) fired_eop = fired;
            if (cy < 3) begin
                in_valid = 1'b1; in_sop = 1'b1; in_sid = 6'(sid);
                in_data = pkt_bytes[0]; in_eop = (n == 1);
            end else if (cy <= tn) begin
                if (acc_cyc[kidx] == cy) begin
                    in_valid = 1'b1; in_sop = (kidx == 0); in_eop = (kidx == n - 1);
                    in_data = pkt_bytes[kidx]; in_sid = 6'($urandom);
                    acc_now = 1'b1;
                    kidx++;
                end else begin
                    in_valid = 1'b0; in_data = 8'($urandom);
                    in_sop = 1'($urandom); in_eop = 1'($urandom);
                end
            end else if (cy < end_c) begin
                in_valid = 1'b1; in_sop = 1'b0; in_eop = 1'b0; in_data = 8'($urandom);
            end else begin
                in_valid = 1'b0;
            end
            res_ready = (cy >= res_c + hold);
            #1;
            n_cmp++;
            if (load_state !== (cy == 1)) begin
                n_bad++; $display("FAIL load_state cyc=%0d got=%b exp=%b", cy, load_state, (cy == 1));
            end
            n_cmp++;
            if (new_stream_id !== (cy == 1 && exp_new)) begin
                n_bad++; $display("FAIL new_stream_id cyc=%0d got=%b exp=%b", cy, new_stream_id, (cy == 1 && exp_new));
            end
            n_cmp++;
            if (in_ready !== (cy >= 3 && cy <= tn)) begin
                n_bad++; $display("FAIL in_ready cyc=%0d got=%b exp=%b", cy, in_ready, (cy >= 3 && cy <= tn));
            end
            if (cy >= 1) begin
                n_cmp++;
                if (stream_id !== 6'(sid)) begin
                    n_bad++; $display("FAIL stream_id cyc=%0d got=%0d exp=%0d", cy, stream_id, sid);
                end
            end
            n_cmp++;
            if (char_in_vld !== acc_prev) begin
                n_bad++; $display("FAIL char_in_vld cyc=%0d got=%b exp=%b", cy, char_in_vld, acc_prev);
            end else if (acc_prev) begin
                n_cmp++;
                if (char_in !== vld_byte) begin
                    n_bad++; $display("FAIL char_in cyc=%0d got=%h exp=%h", cy, char_in, vld_byte);
                end
            end
            n_cmp++;
            if (eop !== (cy == eop_c) || enable !== ((cy == eop_c) ? exp_mask : '0)) begin
                n_bad++; $display("FAIL eop_enable cyc=%0d got=%b/%h exp=%b/%h", cy, eop, enable, (cy == eop_c), exp_mask);
            end
            n_cmp++;
            if (res_valid !== (cy >= res_c && cy < end_c)) begin
                n_bad++; $display("FAIL res_valid cyc=%0d got=%b exp=%b", cy, res_valid, (cy >= res_c && cy < end_c));
            end
            if (cy >= res_c && cy < end_c) begin
                n_cmp++;
                if (res_sid !== 6'(sid) || res_fired !== (fired_eop & exp_mask)) begin
                    n_bad++; $display("FAIL result cyc=%0d got sid=%0d fired=%h exp sid=%0d fired=%h",
                                      cy, res_sid, res_fired, sid, fired_eop & exp_mask);
                end
            end
            n_cmp++;
            if (pkt_count !== 16'((cy >= res_c) ? pkt_m + 1 : pkt_m)) begin
                n_bad++; $display("FAIL pkt_count cyc=%0d got=%0d exp=%0d", cy, pkt_count, (cy >= res_c) ? pkt_m + 1 : pkt_m);
            end
            n_cmp++;
            if (err !== err_m) begin
                n_bad++; $display("FAIL err cyc=%0d got=%b exp=%b", cy, err, err_m);
            end
            acc_prev = acc_now;
            if (acc_now) vld_byte = in_data;
        end
        if (clr_load)
            for (int i = 0; i < 64; i++) seen_m[i] = 1'b0;
        seen_m[sid] = 1'b1;
        if (wr_mid) mask_m[sid] = new_mask;
        pkt_m++;
        $display("pkt sid=%0d len=%0d new=%0b mask=%h res_fired=%h count=%0d hold=%0d",
                 sid, n, exp_new, exp_mask, fired_eop & exp_mask, pkt_m, hold);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({in_ready, char_in, char_in_vld, load_state, new_stream_id, eop, enable, stream_id,
             res_valid, res_sid, res_fired, pkt_count, err} !== '0) begin
            n_bad++; $display("FAIL reset_outputs got pkt=%0d err=%b vld=%b res_valid=%b", pkt_count, err, char_in_vld, res_valid);
        end
        rst = 1'b0;
        model_reset();
        $display("reset done");
    endtask

    task automatic test_first_packet();
        pkt_bytes = '{8'h61, 8'h62, 8'h63};
        run_packet(5, 0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_seen_and_clear();
        fill_bytes(2);
        run_packet(5, 1, 1'b0, 1'b0, 1'b0);
        cfg_clear();
        fill_bytes(4);
        run_packet(5, 0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_mask();
        cfg_write(9, 8'b0000_0101);
        fired_all = 1'b1;
        fill_bytes(3);
        run_packet(9, 0, 1'b0, 1'b0, 1'b1);
        fired_all = 1'b0;
    endtask

    task automatic test_backpressure();
        fill_bytes(2);
        run_packet(9, 10, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_clear_at_load();
        fill_bytes(1);
        run_packet(20, 0, 1'b0, 1'b1, 1'b0);
        fill_bytes(2);
        run_packet(9, 0, 1'b0, 1'b0, 1'b0);
        fill_bytes(2);
        run_packet(20, 0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_err();
        @(posedge clk); #1;
        in_valid = 1'b1; in_sop = 1'b0; in_eop = 1'b0; in_data = 8'($urandom);
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_bad++; $display("FAIL drop_ready got=%b exp=1", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        err_m = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (err !== 1'b1 || load_state !== 1'b0 || char_in_vld !== 1'b0) begin
            n_bad++; $display("FAIL drop_err got err=%b load=%b vld=%b exp 1/0/0", err, load_state, char_in_vld);
        end
        $display("drop beat err=%b", err);
    endtask

    task automatic test_random_packets();
        int sid;
        for (int p = 0; p < 10; p++) begin
            sid = $urandom_range(0, 7);
            if ($urandom_range(0, 1) == 1)
                cfg_write($urandom_range(0, 7), N_REGEX'($urandom));
            fill_bytes($urandom_range(1, 6));
            run_packet(sid, $urandom_range(0, 3), 1'b1,
                       ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0));
        end
    endtask

    task automatic test_reset_mid_packet();
        for (int cy = 0; cy <= 5; cy++) begin
            @(posedge clk); #1;
            in_valid = 1'b1; in_sop = (cy <= 3); in_eop = 1'b0;
            in_sid = 6'd5; in_data = 8'($urandom);
            if (cy == 4) begin
                #1;
                n_cmp++;
                if (char_in_vld !== 1'b1) begin
                    n_bad++; $display("FAIL mid_stream_vld got=%b exp=1", char_in_vld);
                end
            end
            if (cy == 5) begin
                rst = 1'b1; in_valid = 1'b0;
            end
        end
        @(posedge clk); #1;
        n_cmp++;
        if ({in_ready, char_in, char_in_vld, load_state, new_stream_id, eop, enable, stream_id,
             res_valid, res_sid, res_fired, pkt_count, err} !== '0) begin
            n_bad++; $display("FAIL mid_reset_outputs got pkt=%0d err=%b vld=%b sid=%0d", pkt_count, err, char_in_vld, stream_id);
        end
        rst = 1'b0;
        model_reset();
        $display("reset in STREAM");
        fill_bytes(3);
        run_packet(5, 0, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0; in_data = '0; in_sid = '0;
        cfg_we = 1'b0; cfg_clr = 1'b0; cfg_sid = '0; cfg_mask = '0;
        fired = '0; res_ready = 1'b0; fired_all = 1'b0;
        model_reset();
        test_reset();
        test_first_packet();
        test_seen_and_clear();
        test_mask();
        test_backpressure();
        test_err();
        test_clear_at_load();
        test_random_packets();
        test_reset_mid_packet();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
